if_fetch_queue: RTL and testbench

Fetch queue between the IF stage's PC register and the ID stage. Each cycle it issues an instruction-memory read for the current `pc`, allocates an in-order queue entry tagged with that PC, and fills the entry when the memory responds. It presents the head entry to ID as the IF/ID pipeline value. It holds IF via `if_hold`, which drives IF's `hz_PCWrite`, whenever the fetch is not accepted. It also squashes all wrong-path work when `PCSrc` fires.

---
 rtl/if_fetch_queue.sv | 121 ++++++++++++
 tb/tb_if_fetch_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// In-order instruction fetch queue between the IF PC register and the ID stage.
// One fetch per cycle, fills from in-order memory responses, squashes wrong-path work on PCSrc.
module if_fetch_queue #(
    parameter int WORD_BITWIDTH = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_BITWIDTH-1:0] pc,
    input  logic                     PCSrc,
    output logic                     if_hold,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [WORD_BITWIDTH-1:0] imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [WORD_BITWIDTH-1:0] imem_rsp_data,
    output logic                     id_valid,
    output logic [WORD_BITWIDTH-1:0] id_pc,
    output logic [WORD_BITWIDTH-1:0] id_instr,
    input  logic                     id_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0]   LP_DEPTH = DEPTH[PW:0];
    localparam logic [PW-1:0] LP_ONE   = PW'(1);

    typedef enum logic {PRIME, RUN} state_t;

    state_t                   r_state;
    logic [PW-1:0]            r_alloc;
    logic [PW-1:0]            r_fill;
    logic [PW-1:0]            r_head;
    logic [PW-1:0]            r_drop;
    logic [DEPTH-1:0]         r_filled;
    logic [WORD_BITWIDTH-1:0] r_pc_q    [DEPTH];
    logic [WORD_BITWIDTH-1:0] r_instr_q [DEPTH];

    logic                     w_run;
    logic [PW-1:0]            w_occ;
    logic [PW-1:0]            w_outst;
    logic [PW-1:0]            w_rsp_dec;
    logic [PW:0]              w_budget;
    logic [AW-1:0]            w_alloc_idx;
    logic [AW-1:0]            w_fill_idx;
    logic [AW-1:0]            w_head_idx;
    logic                     w_accept;
    logic                     w_pop;
    logic                     w_fill_wr;

    always_comb begin
        w_run          = (r_state == RUN);
        w_occ          = r_alloc - r_head;
        w_outst        = r_alloc - r_fill;
        w_budget       = {1'b0, w_occ} + {1'b0, r_drop};
        w_alloc_idx    = r_alloc[AW-1:0];
        w_fill_idx     = r_fill[AW-1:0];
        w_head_idx     = r_head[AW-1:0];
        w_rsp_dec      = {{AW{1'b0}}, imem_rsp_valid};

        imem_req_addr  = pc;
        imem_req_valid = w_run && !PCSrc && (w_budget < LP_DEPTH);
        w_accept       = imem_req_valid && imem_req_ready;
        // PCSrc must release the hold so IF can load the branch target
        if_hold        = w_run && !PCSrc && !w_accept;

        id_valid       = !PCSrc && (w_occ != '0) && r_filled[w_head_idx];
        id_pc          = '0;
        id_instr       = '0;
        if (w_occ != '0) begin
            id_pc    = r_pc_q[w_head_idx];
            id_instr = r_instr_q[w_head_idx];
        end
        w_pop          = id_valid && id_ready;
        w_fill_wr      = imem_rsp_valid && (r_drop == '0) && !PCSrc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= PRIME;
            r_alloc  <= '0;
            r_fill   <= '0;
            r_head   <= '0;
            r_drop   <= '0;
            r_filled <= '0;
        end else begin
            r_state <= RUN;
            if (PCSrc) begin
                r_alloc <= '0;
                r_fill  <= '0;
                r_head  <= '0;
                // any response this cycle retires one expected response, dropped or not
                r_drop  <= r_drop + w_outst - w_rsp_dec;
            end else begin
                if (w_accept) begin
                    r_filled[w_alloc_idx] <= 1'b0;
                    r_alloc               <= r_alloc + LP_ONE;
                end
                if (imem_rsp_valid) begin
                    if (r_drop != '0) begin
                        r_drop <= r_drop - LP_ONE;
                    end else begin
                        r_filled[w_fill_idx] <= 1'b1;
                        r_fill               <= r_fill + LP_ONE;
                    end
                end
                if (w_pop) begin
                    r_head <= r_head + LP_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc_q[w_alloc_idx] <= pc;
        end
        if (w_fill_wr) begin
            r_instr_q[w_fill_idx] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: IF PC register and in-order instruction memory
// are modelled here; expected outputs are hand-computed per cycle.
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        PCSrc;
    logic [31:0] branch_pc;
    logic        if_hold;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;

    if_fetch_queue #(.WORD_BITWIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .PCSrc(PCSrc), .if_hold(if_hold),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_pc(id_pc),
        .id_instr(id_instr), .id_ready(id_ready)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        int          due;
    } req_t;

    typedef struct {
        bit          rst_before;
        int          lat;
        bit          idr;
        bit          rqr;
        bit          e_hold;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_idv;
        logic [31:0] e_idpc;
        int          e_acc;
    } vec_t;

    req_t mq[$];
    vec_t tbl[$];
    int   cyc;
    int   lat;
    int   acc_cnt;
    int   n_pass = 0;
    int   n_total = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic void add(input bit rb, input int l, input bit idr, input bit rqr,
                                input bit eh, input bit erv, input logic [31:0] ea,
                                input bit eidv, input logic [31:0] eidpc, input int eacc);
        vec_t v;
        v.rst_before = rb; v.lat = l; v.idr = idr; v.rqr = rqr;
        v.e_hold = eh; v.e_rv = erv; v.e_addr = ea;
        v.e_idv = eidv; v.e_idpc = eidpc; v.e_acc = eacc;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%08h, want 0x%08h", nm, cyc, act, exp);
    endtask

    task automatic reset_dut(input int l);
        rst = 1'b0;
        lat = l;
        mq.delete();
        acc_cnt = 0;
        pc = 32'hFFFF_FFFC;
        PCSrc = 1'b0; branch_pc = '0;
        imem_req_ready = 1'b0; id_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        #1;
        chk("rst_if_hold", 32'(if_hold), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic begin_cycle(input bit idr, input bit rqr, input bit pcs, input logic [31:0] bpc);
        id_ready = idr;
        imem_req_ready = rqr;
        PCSrc = pcs;
        branch_pc = bpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mq[0].a);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #4;
    endtask

    task automatic end_cycle();
        logic [31:0] nxt;
        req_t r;
        if (imem_req_valid && imem_req_ready) begin
            r.a = pc;
            r.due = cyc + lat;
            mq.push_back(r);
            acc_cnt++;
        end
        if (imem_rsp_valid) mq.delete(0);
        nxt = if_hold ? pc : (PCSrc ? branch_pc : pc + 32'd4);
        @(posedge clk);
        #1;
        pc = nxt;
        cyc++;
    endtask

    task automatic chk_id(input bit ev, input logic [31:0] epc);
        chk("id_valid", 32'(id_valid), 32'(ev));
        if (ev) begin
            chk("id_pc", id_pc, epc);
            chk("id_instr", id_instr, instr_of(epc));
        end
    endtask

    initial begin
        // prime and streaming, L=1
        add(1, 1, 1, 1, 0, 0, 32'hFFFF_FFFC, 0, 0, -1);
        add(0, 1, 1, 1, 0, 1, 32'h0, 0, 0, -1);
        add(0, 1, 1, 1, 0, 1, 32'h4, 0, 0, -1);
        for (int k = 3; k <= 18; k++) add(0, 1, 1, 1, 0, 1, 32'(4 * (k - 1)), 1, 32'(4 * (k - 3)), -1);
        // ID backpressure for 10 cycles
        add(1, 1, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 0, -1);
        add(0, 1, 0, 1, 0, 1, 32'h0, 0, 0, -1);
        add(0, 1, 0, 1, 0, 1, 32'h4, 0, 0, -1);
        add(0, 1, 0, 1, 0, 1, 32'h8, 1, 0, -1);
        add(0, 1, 0, 1, 0, 1, 32'hC, 1, 0, -1);
        for (int k = 5; k <= 9; k++) add(0, 1, 0, 1, 1, 0, 32'h10, 1, 0, -1);
        add(0, 1, 1, 1, 1, 0, 32'h10, 1, 32'h0, 4);
        add(0, 1, 1, 1, 0, 1, 32'h10, 1, 32'h4, -1);
        add(0, 1, 1, 1, 0, 1, 32'h14, 1, 32'h8, -1);
        add(0, 1, 1, 1, 0, 1, 32'h18, 1, 32'hC, -1);
        add(0, 1, 1, 1, 0, 1, 32'h1C, 1, 32'h10, -1);
        add(0, 1, 1, 1, 0, 1, 32'h20, 1, 32'h14, -1);
        // memory not ready for 3 cycles
        add(1, 1, 1, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, -1);
        add(0, 1, 1, 0, 1, 1, 32'h0, 0, 0, -1);
        add(0, 1, 1, 0, 1, 1, 32'h0, 0, 0, -1);
        add(0, 1, 1, 0, 1, 1, 32'h0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 1, 32'h0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 1, 32'h4, 0, 0, 1);
        add(0, 1, 1, 1, 0, 1, 32'h8, 1, 32'h0, -1);
        add(0, 1, 1, 1, 0, 1, 32'hC, 1, 32'h4, -1);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            if (v.rst_before) reset_dut(v.lat);
            begin_cycle(v.idr, v.rqr, 1'b0, 32'h0);
            chk("if_hold", 32'(if_hold), 32'(v.e_hold));
            chk("req_valid", 32'(imem_req_valid), 32'(v.e_rv));
            chk("req_addr", imem_req_addr, v.e_addr);
            chk_id(v.e_idv, v.e_idpc);
            if (!v.e_idv) chk("id_pc_idle", id_pc, v.e_idpc);
            if (v.e_acc >= 0) chk("accepted", 32'(acc_cnt), 32'(v.e_acc));
            end_cycle();
        end

        // branch flush, L=3, two requests in flight
        reset_dut(3);
        begin_cycle(1, 1, 0, 0); chk("br_c0_rv", 32'(imem_req_valid), 32'd0); end_cycle();
        begin_cycle(1, 1, 0, 0); chk("br_c1_addr", imem_req_addr, 32'h0); end_cycle();
        begin_cycle(1, 1, 0, 0); chk("br_c2_addr", imem_req_addr, 32'h4); end_cycle();
        begin_cycle(1, 1, 1, 32'h100);
        chk("br_flush_rv", 32'(imem_req_valid), 32'd0);
        chk("br_flush_hold", 32'(if_hold), 32'd0);
        chk("br_flush_idv", 32'(id_valid), 32'd0);
        end_cycle();
        begin_cycle(1, 1, 0, 0); chk("br_c4_addr", imem_req_addr, 32'h100);
        chk("br_c4_rv", 32'(imem_req_valid), 32'd1); chk_id(0, 0); end_cycle();
        begin_cycle(1, 1, 0, 0); chk("br_c5_addr", imem_req_addr, 32'h104); chk_id(0, 0); end_cycle();
        begin_cycle(1, 1, 0, 0); chk("br_c6_addr", imem_req_addr, 32'h108); chk_id(0, 0); end_cycle();
        begin_cycle(1, 1, 0, 0); chk("br_c7_addr", imem_req_addr, 32'h10C); chk_id(0, 0); end_cycle();
        begin_cycle(1, 1, 0, 0); chk_id(1, 32'h100);
        chk("br_c8_hold", 32'(if_hold), 32'd1); end_cycle();
        begin_cycle(1, 1, 0, 0); chk_id(1, 32'h104); end_cycle();

        // flush coinciding with a response, L=2, one more request outstanding
        reset_dut(2);
        begin_cycle(1, 1, 0, 0); end_cycle();
        begin_cycle(1, 1, 0, 0); chk("fr_c1_addr", imem_req_addr, 32'h0); end_cycle();
        begin_cycle(1, 1, 0, 0); chk("fr_c2_addr", imem_req_addr, 32'h4); end_cycle();
        begin_cycle(1, 1, 1, 32'h200);
        chk("fr_flush_rv", 32'(imem_req_valid), 32'd0);
        chk("fr_flush_idv", 32'(id_valid), 32'd0);
        end_cycle();
        begin_cycle(1, 1, 0, 0); chk("fr_c4_addr", imem_req_addr, 32'h200); chk_id(0, 0); end_cycle();
        begin_cycle(1, 1, 0, 0); chk("fr_c5_addr", imem_req_addr, 32'h204); chk_id(0, 0); end_cycle();
        begin_cycle(1, 1, 0, 0); chk_id(0, 0); end_cycle();
        begin_cycle(1, 1, 0, 0); chk_id(1, 32'h200); end_cycle();
        begin_cycle(1, 1, 0, 0); chk_id(1, 32'h204); end_cycle();
        begin_cycle(1, 1, 0, 0); chk_id(1, 32'h208); end_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
